// File: rtl/instruction_loader.sv
// instruction_loader: receives a framed byte stream and writes assembled 32-bit instructions into RAM
module instruction_loader #(
   parameter int         ADDR_WIDTH     = 16,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        instruction_write,
   output logic [31:0] instruction_in,
   output logic        debug_enable,
   output logic        busy,
   output logic [15:0] words_loaded,
   output logic [1:0]  load_error
);
   localparam logic [16:0] MAX_WORDS = 17'(2 ** (ADDR_WIDTH - 2));
   localparam int          CW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_WORD, S_FINISH, S_RUN, S_ERROR} state_t;

   state_t        r_state, w_next;
   logic [15:0]   r_len;
   logic [15:0]   r_frame_words;
   logic [1:0]    r_idx;
   logic [23:0]   r_buf;
   logic [CW-1:0] r_cnt;
   logic [15:0]   w_len_full;
   logic          w_in_frame, w_expire, w_word_done, w_last_word;
   logic [1:0]    w_err;
   logic          w_busy, w_dbg;

   assign w_len_full  = {rx_byte, r_len[7:0]};
   assign w_in_frame  = r_state inside {S_LEN0, S_LEN1, S_WORD};
   // a byte arriving in the expiry cycle wins over the timeout
   assign w_expire    = w_in_frame && !rx_valid && r_cnt == TO_LAST;
   assign w_word_done = r_state == S_WORD && rx_valid && r_idx == 2'd3;
   assign w_last_word = r_frame_words + 16'd1 == r_len;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state decode and error classification
   always_comb begin
      w_next = r_state;
      w_err  = 2'b00;
      case (r_state)
         S_IDLE:   if (rx_valid && rx_byte == SYNC_BYTE) w_next = S_LEN0;
         S_LEN0:   if (rx_valid) w_next = S_LEN1;
         S_LEN1:   if (rx_valid) begin
                      if (w_len_full == 16'd0) w_next = S_FINISH;
                      else if ({1'b0, w_len_full} > MAX_WORDS) begin
                         w_next = S_ERROR;
                         w_err  = 2'b10;
                      end
                      else w_next = S_WORD;
                   end
         S_WORD:   if (w_word_done && w_last_word) w_next = S_FINISH;
         S_FINISH: w_next = S_RUN;
         default:  w_next = r_state;
      endcase
      if (w_expire) begin
         w_next = S_ERROR;
         w_err  = 2'b01;
      end
   end

   // status outputs decoded from the upcoming state so the registered copies line up with it
   always_comb begin
      w_busy = w_next inside {S_LEN0, S_LEN1, S_WORD, S_FINISH};
      w_dbg  = w_next == S_RUN;
   end

   // registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy         <= 1'b0;
         debug_enable <= 1'b0;
         load_error   <= 2'b00;
      end else begin
         busy         <= w_busy;
         debug_enable <= w_dbg;
         if (w_next == S_ERROR && r_state != S_ERROR) load_error <= w_err;
      end
   end

   // inter-byte idle counter, zero outside a frame and after every accepted byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else     r_cnt <= (w_in_frame && !rx_valid) ? r_cnt + 1'b1 : '0;
   end

   // length capture, byte lane assembly and word write-out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len             <= '0;
         r_frame_words     <= '0;
         r_idx             <= '0;
         r_buf             <= '0;
         instruction_write <= 1'b0;
         instruction_in    <= '0;
         words_loaded      <= '0;
      end else begin
         instruction_write <= w_word_done;
         if (r_state == S_LEN0 && rx_valid) r_len[7:0] <= rx_byte;
         if (r_state == S_LEN1 && rx_valid) begin
            r_len[15:8]   <= rx_byte;
            r_idx         <= 2'd0;
            r_frame_words <= '0;
         end
         if (r_state == S_WORD && rx_valid) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd0) r_buf[7:0]   <= rx_byte;
            if (r_idx == 2'd1) r_buf[15:8]  <= rx_byte;
            if (r_idx == 2'd2) r_buf[23:16] <= rx_byte;
         end
         if (w_word_done) begin
            instruction_in <= {rx_byte, r_buf};
            r_frame_words  <= r_frame_words + 16'd1;
            words_loaded   <= (words_loaded == 16'hFFFF) ? words_loaded : words_loaded + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed frames checked against a byte-position model of the loader
module tb_instruction_loader;
   localparam int TO   = 8;
   localparam int MAXW = 2 ** (16 - 2);

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        instruction_write;
   logic [31:0] instruction_in;
   logic        debug_enable;
   logic        busy;
   logic [15:0] words_loaded;
   logic [1:0]  load_error;

   int checks = 0;
   int failures = 0;
   logic [31:0] wq[$];

   instruction_loader #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .instruction_write(instruction_write), .instruction_in(instruction_in),
      .debug_enable(debug_enable), .busy(busy), .words_loaded(words_loaded),
      .load_error(load_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%h expected=%h t=%0t", n, a, e, $time);
      end
   endtask

   // model: frame described by bytes consumed after sync, declared length, and cycle stamps
   int          m_cyc = 0, m_last = 0, m_pos = 0, m_len = 0, m_done_cyc = 0;
   bit          m_act = 0, m_done = 0, m_wr = 0;
   logic [1:0]  m_err = 0;
   logic [15:0] m_words = 0;
   logic [31:0] m_instr = 0;
   logic [7:0]  m_buf[4];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc = 0; m_last = 0; m_pos = 0; m_len = 0; m_done_cyc = 0;
         m_act = 0; m_done = 0; m_wr = 0; m_err = 0; m_words = 0; m_instr = 0;
      end else begin
         m_cyc++;
         m_wr = 0;
         if (!m_done && m_err == 0) begin
            if (!m_act) begin
               if (rx_valid && rx_byte == 8'hA5) begin m_act = 1; m_pos = 0; m_last = m_cyc; end
            end else if (rx_valid) begin
               m_last = m_cyc;
               m_pos++;
               if (m_pos == 1) m_len = rx_byte;
               else if (m_pos == 2) begin
                  m_len += 256 * rx_byte;
                  if (m_len == 0) begin m_done = 1; m_done_cyc = m_cyc; m_act = 0; end
                  else if (m_len > MAXW) m_err = 2'b10;
               end else begin
                  m_buf[(m_pos - 3) % 4] = rx_byte;
                  if ((m_pos - 3) % 4 == 3) begin
                     m_wr = 1;
                     m_instr = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                     if (m_words != 16'hFFFF) m_words++;
                     if (m_pos == 2 + 4 * m_len) begin m_done = 1; m_done_cyc = m_cyc; m_act = 0; end
                  end
               end
            end else if (m_cyc - m_last >= TO) m_err = 2'b01;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("write", instruction_write, m_wr);
      chk("instr", instruction_in, m_instr);
      chk("busy", busy, (m_act && m_err == 0) || (m_done && m_cyc == m_done_cyc));
      chk("debug", debug_enable, m_done && m_cyc > m_done_cyc);
      chk("words", words_loaded, m_words);
      chk("error", load_error, m_err);
      if (instruction_write === 1'b1) wq.push_back(instruction_in);
   end

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #2 rx_valid = 1'b0;
   endtask

   task automatic send_list(input logic [7:0] bs[$]);
      foreach (bs[i]) send(bs[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_rst;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      wq.delete();
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_debug", debug_enable, 1'b0);
      chk("reset_words", words_loaded, 16'd0);
      chk("reset_instr", instruction_in, 32'd0);

      send_list('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
      @(negedge clk);
      chk("two_last_write", instruction_write, 1'b1);
      chk("two_last_debug", debug_enable, 1'b0);
      @(negedge clk);
      chk("two_debug_rise", debug_enable, 1'b1);
      chk("two_write_drop", instruction_write, 1'b0);
      chk("two_count", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("two_w0", wq[0], 32'h00000013);
         chk("two_w1", wq[1], 32'h00100093);
      end
      chk("two_words", words_loaded, 16'd2);

      send_list('{8'hA5, 8'h05, 8'h00});
      idle(5);
      chk("run_ignore_writes", wq.size(), 2);
      chk("run_ignore_debug", debug_enable, 1'b1);
      chk("run_ignore_busy", busy, 1'b0);
      chk("run_ignore_instr", instruction_in, 32'h00100093);

      pulse_rst;
      send_list('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00});
      @(negedge clk);
      chk("zero_finish_busy", busy, 1'b1);
      chk("zero_finish_debug", debug_enable, 1'b0);
      @(negedge clk);
      chk("zero_debug", debug_enable, 1'b1);
      chk("zero_words", words_loaded, 16'd0);
      chk("zero_writes", wq.size(), 0);

      pulse_rst;
      send_list('{8'hA5, 8'h01, 8'h40});
      idle(20);
      chk("len_err_code", load_error, 2'b10);
      chk("len_err_debug", debug_enable, 1'b0);
      chk("len_err_writes", wq.size(), 0);

      pulse_rst;
      send_list('{8'hA5, 8'h01, 8'h00, 8'hAA});
      idle(20);
      chk("to_err_code", load_error, 2'b01);
      chk("to_err_debug", debug_enable, 1'b0);
      chk("to_err_busy", busy, 1'b0);
      chk("to_err_writes", wq.size(), 0);

      pulse_rst;
      send_list('{8'hA5, 8'h01, 8'h00, 8'hAA});
      idle(TO - 1);
      send_list('{8'h11, 8'h22, 8'h33});
      idle(3);
      chk("edge_no_err", load_error, 2'b00);
      chk("edge_count", wq.size(), 1);
      if (wq.size() == 1) chk("edge_word", wq[0], 32'h332211AA);
      chk("edge_debug", debug_enable, 1'b1);

      pulse_rst;
      send_list('{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD});
      pulse_rst;
      send_list('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
      idle(3);
      chk("rst_mid_count", wq.size(), 1);
      if (wq.size() == 1) chk("rst_mid_word", wq[0], 32'hDEADBEEF);
      chk("rst_mid_words", words_loaded, 16'd1);
      chk("rst_mid_debug", debug_enable, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
